// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizing, drain state encoding and PE flattening rule for the systolic datapath
package systolic_pkg;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic int o_bits(input int i_bits, input int dimension);
        return (i_bits * 2) + $clog2(dimension);
    endfunction

    function automatic int idx_bits(input int dimension);
        return $clog2(dimension * dimension);
    endfunction

    function automatic int flat_idx(input int r, input int c, input int dimension);
        return r * dimension + c;
    endfunction
endpackage

// File: rtl/systolic_result_drain_if.sv
// systolic_result_drain_if: row-major result stream toward the output FIFO
interface systolic_result_drain_if #(
    parameter int O_BITS  = 18,
    parameter int RC_BITS = 2
);
    logic [O_BITS-1:0]  o_data;
    logic [RC_BITS-1:0] o_row;
    logic [RC_BITS-1:0] o_col;
    logic               o_last;
    logic               o_valid;
    logic               i_ready;

    modport master (output o_data, o_row, o_col, o_last, o_valid, input i_ready);
    modport slave  (input o_data, o_row, o_col, o_last, o_valid, output i_ready);
endinterface

// File: rtl/drain_slot.sv
// drain_slot: two-entry ping-pong result slot for one PE, with capture, bank clear and drop detection
module drain_slot #(
    parameter int O_BITS = 18
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_finish,
    input  logic [O_BITS-1:0] i_c,
    input  logic              i_clear,
    input  logic              i_bank,
    output logic [1:0]        o_full,
    output logic [O_BITS-1:0] o_data,
    output logic              o_drop
);
    logic                   wr_sel_q, wr_sel_d;
    logic [1:0]             full_q, full_d;
    logic [1:0][O_BITS-1:0] mem_q, mem_d;
    logic                   capture;

    // Clear is applied before the capture test so a strobe landing on a slot freed this edge is kept.
    always_comb begin
        full_d = full_q;
        if (i_clear) full_d[i_bank] = 1'b0;
        capture  = i_finish && !full_d[wr_sel_q];
        o_drop   = i_finish && !capture;
        wr_sel_d = wr_sel_q ^ capture;
        mem_d    = mem_q;
        if (capture) begin
            mem_d[wr_sel_q]  = i_c;
            full_d[wr_sel_q] = 1'b1;
        end
    end

    // Slot state registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_sel_q <= 1'b0;
            full_q   <= '0;
            mem_q    <= '0;
        end else begin
            wr_sel_q <= wr_sel_d;
            full_q   <= full_d;
            mem_q    <= mem_d;
        end
    end

    assign o_full = full_q;
    assign o_data = mem_q[i_bank];
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures the PE wavefront into ping-pong banks and streams each matrix row-major
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DIMENSION = 4,
    parameter int I_BITS    = 8,
    parameter int O_BITS    = o_bits(I_BITS, DIMENSION)
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic [DIMENSION*DIMENSION*O_BITS-1:0] i_c,
    input  logic [DIMENSION*DIMENSION-1:0]      i_finish,
    systolic_result_drain_if.master             o_stream,
    output logic                                o_overflow
);
    localparam int N  = DIMENSION * DIMENSION;
    localparam int IW = idx_bits(DIMENSION);
    localparam int RW = $clog2(DIMENSION);

    logic [O_BITS-1:0] word [N];
    logic [N-1:0]      full_rd, drop;
    logic              clear, last;
    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, idx_nx;
    logic              rd_bank_q, rd_bank_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic [O_BITS-1:0] data_q, data_d;

    for (genvar k = 0; k < N; k++) begin : g_slot
        logic [1:0] full;
        drain_slot #(.O_BITS(O_BITS)) u_slot (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_finish (i_finish[k]),
            .i_c      (i_c[k*O_BITS +: O_BITS]),
            .i_clear  (clear),
            .i_bank   (rd_bank_q),
            .o_full   (full),
            .o_data   (word[k]),
            .o_drop   (drop[k])
        );
        assign full_rd[k] = full[rd_bank_q];
    end

    assign last = idx_q == IW'(N - 1);

    // Drain FSM: start when the read bank is complete, step on each handshake, release the bank after the last word.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_bank_d  = rd_bank_q;
        valid_d    = valid_q;
        data_d     = data_q;
        clear      = 1'b0;
        idx_nx     = idx_q + 1'b1;
        overflow_d = overflow_q | (|drop);
        if (state_q == ST_IDLE) begin
            if (&full_rd) begin
                state_d = ST_DRAIN;
                idx_d   = '0;
                valid_d = 1'b1;
                data_d  = word[0];
            end
        end else if (o_stream.i_ready) begin
            if (last) begin
                clear     = 1'b1;
                rd_bank_d = !rd_bank_q;
                state_d   = ST_IDLE;
                idx_d     = '0;
                valid_d   = 1'b0;
            end else begin
                idx_d  = idx_nx;
                data_d = word[idx_nx];
            end
        end
    end

    // Drain and output registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rd_bank_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_bank_q  <= rd_bank_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_stream.o_valid = valid_q;
    assign o_stream.o_data  = data_q;
    assign o_stream.o_row   = RW'(idx_q / IW'(DIMENSION));
    assign o_stream.o_col   = RW'(idx_q % IW'(DIMENSION));
    assign o_stream.o_last  = valid_q && last;
    assign o_overflow       = overflow_q;
endmodule
